mem_arbiter: RTL and testbench

Shares one single-ported external memory between the MIPS core's instruction-fetch port and its load/store data port. It replaces the dual-ported memory model when the design targets a single physical memory. Each requester uses a level request / one-cycle acknowledge handshake. The arbiter serialises accesses through a fixed four-state sequence and returns read data in registers.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEF = 8;
    localparam int IW_DEF = 32;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the single-port memory bus, bundled for the arbiter.
// slave = arbiter side, master = core requesters and memory side.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [IW-1:0] if_rdata;
    logic          if_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [IW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way grant selector. MEM_ARB_RR_EN selects round-robin on conflicts;
// otherwise data always beats instruction fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_if_req,
    input  logic i_d_req,
`ifdef MEM_ARB_RR_EN
    input  gnt_t i_last_gnt,
`endif
    output logic o_valid,
    output gnt_t o_gnt
);

    always_comb begin
        o_valid = i_if_req | i_d_req;
`ifdef MEM_ARB_RR_EN
        if (i_if_req && i_d_req) begin
            o_gnt = (i_last_gnt == GNT_IF) ? GNT_D : GNT_IF;
        end else begin
            o_gnt = i_d_req ? GNT_D : GNT_IF;
        end
`else
        o_gnt = i_d_req ? GNT_D : GNT_IF;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data loads/stores onto one memory port
// through IDLE/ISSUE/WAIT/ACK. Optional MEM_ARB_RR_EN enables round-robin.
//
// state | meaning
// IDLE  | sample requests, latch the winner
// ISSUE | drive one-cycle read or write strobe
// WAIT  | memory returns data; capture it on reads
// ACK   | one-cycle ack to the granted requester
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int IW = IW_DEF,
    parameter int DW = DW_DEF
)(
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    gnt_t          r_gnt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [IW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_valid;
    gnt_t          w_gnt;
    logic          w_mem_re;
    logic          w_mem_we;
    logic [DW-1:0] w_mem_wdata;
    logic          w_if_ack;
    logic          w_d_ack;

`ifdef MEM_ARB_RR_EN
    gnt_t          r_last_gnt;
`endif

    mem_arb_pick u_pick (
        .i_if_req   (bus.if_req),
        .i_d_req    (bus.d_req),
`ifdef MEM_ARB_RR_EN
        .i_last_gnt (r_last_gnt),
`endif
        .o_valid    (w_valid),
        .o_gnt      (w_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wdata = '0;
        w_if_ack    = 1'b0;
        w_d_ack     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_mem_re    = ~r_we;
                w_mem_we    = r_we;
                w_mem_wdata = r_we ? r_wdata : '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                w_state_nxt = ACK;
            end
            ACK: begin
                w_if_ack    = (r_gnt == GNT_IF);
                w_d_ack     = (r_gnt == GNT_D);
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= GNT_IF;
            r_addr     <= '0;
            r_we       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_valid) begin
                r_gnt <= w_gnt;
                if (w_gnt == GNT_D) begin
                    r_addr  <= bus.d_addr;
                    r_we    <= bus.d_we;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_addr  <= bus.if_addr;
                    r_we    <= 1'b0;
                    r_wdata <= '0;
                end
            end
            // Stores leave both read-data registers untouched.
            if (r_state == WAIT && !r_we) begin
                if (r_gnt == GNT_D) begin
                    r_d_rdata <= bus.mem_rdata[DW-1:0];
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= GNT_IF;
        end else if (r_state == IDLE && w_valid) begin
            r_last_gnt <= w_gnt;
        end
    end
`endif

    assign bus.mem_addr  = r_addr;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.if_ack    = w_if_ack;
    assign bus.d_ack     = w_d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected accesses in grant
// order, with a small byte-write / word-read memory model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if #(.AW(8), .IW(32), .DW(8)) bus ();

    mem_arbiter #(.AW(8), .IW(32), .DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_words [0:255];
    logic [31:0] mem_rd;

    always @(posedge clk) begin
        if (bus.mem_we) mem_words[bus.mem_addr][7:0] <= bus.mem_wdata;
        if (bus.mem_re) mem_rd <= mem_words[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_rd;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [7:0] last_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic is_d, input logic we, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.is_d  = is_d;
        e.we    = we;
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = rdata;
        sb.push_back(e);
    endtask

    // Waits for the next strobe, checks it against the scoreboard head, then
    // follows the access through to its ack.
    task automatic serve(input string tag, input int exp_wait);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        n = 0;
        do begin
            step();
            n++;
        end while (!(bus.mem_re || bus.mem_we) && n < 12);
        if (!(bus.mem_re || bus.mem_we)) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_wait"},   n, exp_wait);
        chk({tag, "_mem_re"}, {31'd0, bus.mem_re}, {31'd0, ~e.we});
        chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, {31'd0, e.we});
        chk({tag, "_addr"},   {24'd0, bus.mem_addr}, {24'd0, e.addr});
        chk({tag, "_wdata"},  {24'd0, bus.mem_wdata}, {24'd0, (e.we ? e.wdata : 8'd0)});
        chk({tag, "_acks_issue"}, {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        step();
        chk({tag, "_strobe_off"}, {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk({tag, "_acks_wait"},  {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        step();
        chk({tag, "_if_ack"}, {31'd0, bus.if_ack}, {31'd0, ~e.is_d});
        chk({tag, "_d_ack"},  {31'd0, bus.d_ack},  {31'd0, e.is_d});
        if (e.is_d) begin
            if (!e.we) last_d = e.rdata[7:0];
            chk({tag, "_d_rdata"}, {24'd0, bus.d_rdata}, {24'd0, last_d});
        end else begin
            chk({tag, "_if_rdata"}, bus.if_rdata, e.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_words[i] = 32'd0;
        mem_words[4]  = 32'h20020005;
        mem_words[5]  = 32'h11223344;
        mem_words[16] = 32'hCAFE00AB;
        mem_rd = 32'd0;
        last_d = 8'd0;

        rst          = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 8'h04;
        bus.d_req    = 1'b1;
        bus.d_we     = 1'b0;
        bus.d_addr   = 8'h10;
        bus.d_wdata  = 8'h00;

        // Reset held with both requests pending
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rst_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
            chk("rst_acks",    {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        end
        chk("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        chk("rst_if_rdata", bus.if_rdata, 32'd0);
        chk("rst_d_rdata",  {24'd0, bus.d_rdata}, 32'd0);
        rst = 1'b0;

        // Conflict from reset, both requests held
`ifdef MEM_ARB_RR_EN
        push(1'b1, 1'b0, 8'h10, 8'h00, 32'hCAFE00AB);
        push(1'b0, 1'b0, 8'h04, 8'h00, 32'h20020005);
        push(1'b1, 1'b0, 8'h10, 8'h00, 32'hCAFE00AB);
        push(1'b0, 1'b0, 8'h04, 8'h00, 32'h20020005);
`else
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 8'h10, 8'h00, 32'hCAFE00AB);
`endif
        serve("conflict0", 1);
        serve("conflict1", 2);
        serve("conflict2", 2);
        serve("conflict3", 2);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        step();
        chk("conflict_ack_pulse", {30'd0, bus.if_ack, bus.d_ack}, 32'd0);

        // Lone fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 8'h04;
        push(1'b0, 1'b0, 8'h04, 8'h00, 32'h20020005);
        serve("fetch", 1);
        bus.if_req = 1'b0;
        step();
        chk("fetch_ack_pulse", {31'd0, bus.if_ack}, 32'd0);
        chk("fetch_rdata_hold", bus.if_rdata, 32'h20020005);

        // Store to address 5
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 8'h05;
        bus.d_wdata = 8'h07;
        push(1'b1, 1'b1, 8'h05, 8'h07, 32'd0);
        serve("store", 1);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        step();
        chk("store_ack_pulse", {31'd0, bus.d_ack}, 32'd0);

        // Load back the stored byte
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h05;
        push(1'b1, 1'b0, 8'h05, 8'h00, 32'h11223307);
        serve("load", 1);
        bus.d_req = 1'b0;
        step();

        // Reset while the load is in WAIT
        bus.d_req  = 1'b1;
        bus.d_addr = 8'h10;
        step();
        chk("midrst_issue_re", {31'd0, bus.mem_re}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_d = 8'd0;
        chk("midrst_acks",    {30'd0, bus.if_ack, bus.d_ack}, 32'd0);
        chk("midrst_strobes", {30'd0, bus.mem_re, bus.mem_we}, 32'd0);
        chk("midrst_d_rdata", {24'd0, bus.d_rdata}, 32'd0);
        chk("midrst_if_rdata", bus.if_rdata, 32'd0);
        push(1'b1, 1'b0, 8'h10, 8'h00, 32'hCAFE00AB);
        serve("reserve", 1);
        bus.d_req = 1'b0;
        step();
        chk("reserve_ack_pulse", {31'd0, bus.d_ack}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
